mem_port_arbiter: RTL

- Arbitrates one single-port unified instruction/data SRAM between the IF stage (instruction fetch, read-only) and the MEM stage (load/store fed by the EXE/MEM pipeline register).
- Sequences each access through a programmable-latency wait counter.
- Returns per-requester ready pulses; the pipeline uses `!ready` as its stall condition.
- Sits between the pipeline front/back ends and the memory macro.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/access_timer.sv | 37 +++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified SRAM port arbiter: FSM states, grant encoding, timer width.
// Pure declarations; no latency or flow control of its own.
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACC_IF,
        ACC_MEM
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IF,
        GNT_MEM
    } gnt_t;

endpackage

// File: rtl/access_timer.sv
// Loadable down-counter that times one SRAM access; done flags a zero count.
// Load takes effect next cycle; dec holds at zero; there is no backpressure.
module access_timer
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;
    assign done  = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM between IF and MEM (MEM wins); ready pulses WAIT_CYCLES after the grant, then one IDLE cycle.
// Losers simply see ready=0 and stall. MEM_ARB_PERF_CNT_EN adds per-requester stall counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd_req,
    input  logic              mem_wr_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_stall,
    output logic [31:0]       perf_mem_stall
`endif
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    gnt_t              gnt;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              en_q, en_d;
    logic              tmr_load, tmr_dec, tmr_done;
    logic [CNT_W-1:0]  tmr_value;

    // MEM is the older instruction, so it always wins a simultaneous request.
    always_comb begin
        gnt = GNT_NONE;
        if (state_q == IDLE) begin
            if (mem_wr_req || mem_rd_req) begin
                gnt = GNT_MEM;
            end else if (if_req) begin
                gnt = GNT_IF;
            end
        end
    end

    assign tmr_load = (gnt != GNT_NONE);
    assign tmr_dec  = (state_q != IDLE);

    access_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (LOAD_VAL),
        .value    (tmr_value),
        .done     (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        en_d      = en_q;
        if_ready  = 1'b0;
        mem_ready = 1'b0;
        if_rdata  = '0;
        mem_rdata = '0;
        case (state_q)
            IDLE: begin
                if (gnt == GNT_MEM) begin
                    state_d = ACC_MEM;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    we_d    = mem_wr_req;
                    en_d    = 1'b1;
                end else if (gnt == GNT_IF) begin
                    state_d = ACC_IF;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    we_d    = 1'b0;
                    en_d    = 1'b1;
                end
            end
            ACC_IF, ACC_MEM: begin
                // Enable stays up until the final count of the access.
                en_d = (tmr_value != '0);
                if (tmr_done) begin
                    state_d = IDLE;
                    we_d    = 1'b0;
                    if (state_q == ACC_IF) begin
                        if_ready = 1'b1;
                        if_rdata = sram_rdata;
                    end else begin
                        mem_ready = 1'b1;
                        mem_rdata = we_q ? '0 : sram_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            if_ready  = 1'b0;
            mem_ready = 1'b0;
            if_rdata  = '0;
            mem_rdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            en_q    <= en_d;
        end
    end

    assign sram_en    = en_q;
    assign sram_we    = we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_if_stall_q, perf_if_stall_d;
    logic [31:0] perf_mem_stall_q, perf_mem_stall_d;

    always_comb begin
        perf_if_stall_d  = perf_if_stall_q + 32'(if_req && !if_ready);
        perf_mem_stall_d = perf_mem_stall_q + 32'((mem_rd_req || mem_wr_req) && !mem_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_stall_q  <= '0;
            perf_mem_stall_q <= '0;
        end else begin
            perf_if_stall_q  <= perf_if_stall_d;
            perf_mem_stall_q <= perf_mem_stall_d;
        end
    end

    assign perf_if_stall  = perf_if_stall_q;
    assign perf_mem_stall = perf_mem_stall_q;
`endif

endmodule
